sm83_instr_assembler: RTL
=========================

# sm83_instr_assembler

Parametrised successor to the SM83 single-byte decoder. It sits between instruction fetch and decode and consumes a byte stream over a valid/ready handshake. It length-decodes each SM83 instruction (1–3 bytes, including the CB prefix), collects its operand bytes, and tags each instruction with its PC. Completed instruction packets are buffered in a DEPTH-entry FIFO that decode pops. A flush (taken branch, interrupt) empties the FIFO and redirects the byte PC.

## Interface
- DEPTH, 2, packet FIFO entries; power of two, ≥1
- PC_W, 16, PC width; PC arithmetic is modulo 2^PC_W
- RESET_PC, 0, byte PC after reset
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush_i  in  1  discard the partial instruction and all buffered packets
- flush_pc_i  in  PC_W  PC of the first byte after a flush
- byte_valid_i  in  1  fetch byte valid
- byte_i  in  8  fetch byte
- byte_ready_o  out  1  byte accepted when byte_valid_i && byte_ready_o
- pkt_valid_o  out  1  FIFO head valid
- pkt_ready_i  in  1  decode pops the head when pkt_valid_o && pkt_ready_i
- pkt_opcode_o  out  8  opcode; for CB instructions, the byte after CB
- pkt_cb_o  out  1  instruction is CB-prefixed
- pkt_imm_o  out  16  immediate, zero-extended
- pkt_len_o  out  2  instruction length in bytes: 1, 2 or 3
- pkt_pc_o  out  PC_W  PC of the first byte (the CB byte for prefixed instructions)
- pkt_illegal_o  out  1  opcode is unassigned
- count_o  out  $clog2(DEPTH+1)  occupied FIFO entries

## Operation
- Assembler FSM states: S_OP, S_CB, S_IMM_LO, S_IMM_HI. Reset state is S_OP.
- S_OP, byte accepted: latch opcode and pc.
  - If the byte is CB: go to S_CB.
  - If its length is 1: push the packet; stay in S_OP.
  - Otherwise: go to S_IMM_LO.
- S_CB, byte accepted: push {opcode=byte, cb=1, len=2, imm=0}; go to S_OP.
- S_IMM_LO, byte accepted: imm[7:0]=byte.
  - Length 2: push with imm[15:8]=0; go to S_OP.
  - Length 3: go to S_IMM_HI.
- S_IMM_HI, byte accepted: imm[15:8]=byte; push; go to S_OP. Immediates are little-endian.
- Length-2 opcodes:
  - 00xxx110 (LD r,d8 / LD (HL),d8)
  - 11xxx110 (ALU A,d8)
  - 10, 18, 20, 28, 30, 38
  - E0, E8, F0, F8
- Length-3 opcodes:
  - 01, 11, 21, 31, 08
  - C2, C3, C4, CA, CC, CD
  - D2, D4, DA, DC
  - EA, FA
- Illegal opcodes: D3, DB, DD, E3, E4, EB, EC, ED, F4, FC, FD. They are length 1 with pkt_illegal_o=1.
- All other opcodes are length 1 with pkt_illegal_o=0.
- byte_ready_o = !flush_i && (count < DEPTH). This is conservative: non-final bytes also stall when the FIFO is full.
- The byte PC increments by 1 on every accepted byte and wraps from 2^PC_W−1 to 0.
- FIFO:
  - First-word-fall-through; pkt_* always reflect the head entry.
  - A simultaneous push and pop when not full is legal, and count is unchanged.
  - With an empty FIFO, pkt_* other than pkt_valid_o hold their last values and carry no meaning.
- Flush (has priority over everything):
  - count → 0 and FSM → S_OP.
  - pc → flush_pc_i and partial opcode/imm are dropped.
  - byte_ready_o is low that cycle, so no byte is accepted.
  - A pop in the same cycle has no additional effect.

## Timing
- Reset values:
  - pkt_valid_o=0, count_o=0, FSM=S_OP, pc=RESET_PC.
  - pkt_opcode_o, pkt_cb_o, pkt_imm_o, pkt_len_o, pkt_illegal_o = 0; pkt_pc_o=0.
  - byte_ready_o=1 (combinational, follows flush_i).
- Latency: a packet is visible on pkt_* the cycle after its final byte is accepted.
- The minimum packet interval equals the instruction length in cycles.
- Full FIFO: a pop in cycle N raises byte_ready_o in cycle N+1, not the same cycle, because ready comes from the registered count.
- After flush_i in cycle N:
  - pkt_valid_o=0 and byte_ready_o=1 in cycle N+1 (if flush_i has deasserted).
  - The first accepted byte carries PC flush_pc_i.
- Asserting rst_n mid-instruction discards the partial instruction and the FIFO contents immediately (asynchronous).

## Test plan
- Reset, send 3E 42 with pkt_ready_i=1 → one packet: opcode 3E, len 2, imm 0042, pc 0000, cb 0, illegal 0, valid one cycle after 42.
- Send C3 34 12 then CB 7C → packet 1: len 3, imm 1234, pc 0000. Packet 2: cb 1, opcode 7C, len 2, pc 0003, imm 0000.
- DEPTH=2, pkt_ready_i=0, send 00 00 AF → count_o=2 and byte_ready_o=0 with AF held. Pulse pkt_ready_i → head popped, AF accepted the next cycle, pkt_pc_o of AF = 0002.
- Send C3 34, then flush_i with flush_pc_i=0150 while byte_valid_i is high → byte not accepted, count 0. Then AF → packet opcode AF, len 1, pc 0150.
- RESET_PC=FFFF, send 01 CD AB 00 → packet opcode 01, imm ABCD, pc FFFF. Next packet opcode 00, pc 0002.
- Send D3 then DD → two packets, each len 1, illegal 1, pc 0000 and 0001. Release rst_n low mid C3 34 → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/sm83_instr_assembler_if.sv
// sm83_instr_assembler_if
// Bundles the fetch-side byte stream, the decode-side packet stream, the
// flush/redirect request and the FIFO occupancy of the instruction assembler.
//   master : fetch/decode side (drives bytes, flush, pops packets)
//   slave  : the assembler (accepts bytes, presents packets, reports count)
// Ports carried:
//   flush_i, flush_pc_i                : discard everything, redirect byte PC
//   byte_valid_i, byte_i, byte_ready_o : fetch byte handshake
//   pkt_valid_o, pkt_ready_i           : packet FIFO head handshake
//   pkt_opcode_o, pkt_cb_o, pkt_imm_o,
//   pkt_len_o, pkt_pc_o, pkt_illegal_o : head packet fields
//   count_o                            : occupied FIFO entries
interface sm83_instr_assembler_if #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 16
) ();
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             flush_i;
  logic [PC_W-1:0]  flush_pc_i;
  logic             byte_valid_i;
  logic [7:0]       byte_i;
  logic             byte_ready_o;
  logic             pkt_valid_o;
  logic             pkt_ready_i;
  logic [7:0]       pkt_opcode_o;
  logic             pkt_cb_o;
  logic [15:0]      pkt_imm_o;
  logic [1:0]       pkt_len_o;
  logic [PC_W-1:0]  pkt_pc_o;
  logic             pkt_illegal_o;
  logic [CNT_W-1:0] count_o;

  modport master (
    output flush_i, flush_pc_i, byte_valid_i, byte_i, pkt_ready_i,
    input  byte_ready_o, pkt_valid_o, pkt_opcode_o, pkt_cb_o, pkt_imm_o,
           pkt_len_o, pkt_pc_o, pkt_illegal_o, count_o
  );

  modport slave (
    input  flush_i, flush_pc_i, byte_valid_i, byte_i, pkt_ready_i,
    output byte_ready_o, pkt_valid_o, pkt_opcode_o, pkt_cb_o, pkt_imm_o,
           pkt_len_o, pkt_pc_o, pkt_illegal_o, count_o
  );
endinterface

// File: rtl/sm83_instr_assembler.sv
// sm83_instr_assembler
// Length-decodes an SM83 byte stream (1-3 byte instructions, CB prefix
// included), gathers operand bytes, tags each instruction with the PC of its
// first byte and queues finished packets in a DEPTH-entry first-word-fall-
// through FIFO. A flush empties the FIFO, drops any partial instruction and
// redirects the byte PC.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : sm83_instr_assembler_if.slave (byte in, packet out, flush, count)
module sm83_instr_assembler #(
  parameter int              DEPTH    = 2,
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sm83_instr_assembler_if.slave   bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_OP     = 2'd0,
    S_CB     = 2'd1,
    S_IMM_LO = 2'd2,
    S_IMM_HI = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0]      opcode;
    logic            cb;
    logic [15:0]     imm;
    logic [1:0]      len;
    logic [PC_W-1:0] pc;
    logic            illegal;
  } pkt_t;

  // Total length of a non-CB opcode (CB is routed separately by the FSM).
  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [1:0] len;
    case (op)
      8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
      8'hE0, 8'hE8, 8'hF0, 8'hF8:                 len = 2'd2;
      8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
      8'hC2, 8'hC3, 8'hC4, 8'hCA, 8'hCC, 8'hCD,
      8'hD2, 8'hD4, 8'hDA, 8'hDC,
      8'hEA, 8'hFA:                               len = 3'd3 & 2'd3;
      default: begin
        // 00xxx110 (LD r,d8) and 11xxx110 (ALU A,d8) carry one operand byte.
        if ((op[2:0] == 3'b110) && (op[7:6] == 2'b00 || op[7:6] == 2'b11)) begin
          len = 2'd2;
        end else begin
          len = 2'd1;
        end
      end
    endcase
    return len;
  endfunction

  // Unassigned opcodes of the base table.
  function automatic logic op_illegal(input logic [7:0] op);
    logic ill;
    case (op)
      8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
      8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD:          ill = 1'b1;
      default:                                    ill = 1'b0;
    endcase
    return ill;
  endfunction

  // Circular pointer advance that also handles non power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == PTR_W'(DEPTH - 1)) begin
      n = {PTR_W{1'b0}};
    end else begin
      n = p + PTR_W'(1);
    end
    return n;
  endfunction

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [7:0]       op_q, op_d;
  logic [PC_W-1:0]  op_pc_q, op_pc_d;
  logic [1:0]       len_q, len_d;
  logic [7:0]       imm_lo_q, imm_lo_d;

  pkt_t             mem_q [DEPTH];
  pkt_t             mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             flush_s;
  logic             ready_s;
  logic             accept_s;
  logic             pop_s;
  logic             push_s;
  pkt_t             push_pkt_s;
  pkt_t             head_s;

  // Ready is taken from the registered count, so it stalls even non-final bytes.
  assign flush_s  = bus.flush_i;
  assign ready_s  = !flush_s && (count_q < CNT_W'(DEPTH));
  assign accept_s = bus.byte_valid_i && ready_s;
  assign pop_s    = (count_q != {CNT_W{1'b0}}) && bus.pkt_ready_i;
  assign head_s   = mem_q[rd_ptr_q];

  assign bus.byte_ready_o  = ready_s;
  assign bus.pkt_valid_o   = (count_q != {CNT_W{1'b0}});
  assign bus.pkt_opcode_o  = head_s.opcode;
  assign bus.pkt_cb_o      = head_s.cb;
  assign bus.pkt_imm_o     = head_s.imm;
  assign bus.pkt_len_o     = head_s.len;
  assign bus.pkt_pc_o      = head_s.pc;
  assign bus.pkt_illegal_o = head_s.illegal;
  assign bus.count_o       = count_q;

  // Assembler FSM: next state, byte PC and packet construction.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    op_d       = op_q;
    op_pc_d    = op_pc_q;
    len_d      = len_q;
    imm_lo_d   = imm_lo_q;
    push_s     = 1'b0;
    push_pkt_s = '0;
    if (flush_s) begin
      state_d = S_OP;
      pc_d    = bus.flush_pc_i;
    end else if (accept_s) begin
      pc_d = pc_q + PC_W'(1);
      case (state_q)
        S_OP: begin
          op_d    = bus.byte_i;
          op_pc_d = pc_q;
          len_d   = op_len(bus.byte_i);
          if (bus.byte_i == 8'hCB) begin
            state_d = S_CB;
          end else if (op_len(bus.byte_i) == 2'd1) begin
            push_s     = 1'b1;
            push_pkt_s = '{opcode: bus.byte_i, cb: 1'b0, imm: 16'h0000, len: 2'd1,
                           pc: pc_q, illegal: op_illegal(bus.byte_i)};
          end else begin
            state_d = S_IMM_LO;
          end
        end
        S_CB: begin
          push_s     = 1'b1;
          push_pkt_s = '{opcode: bus.byte_i, cb: 1'b1, imm: 16'h0000, len: 2'd2,
                         pc: op_pc_q, illegal: 1'b0};
          state_d    = S_OP;
        end
        S_IMM_LO: begin
          imm_lo_d = bus.byte_i;
          if (len_q == 2'd2) begin
            push_s     = 1'b1;
            push_pkt_s = '{opcode: op_q, cb: 1'b0, imm: {8'h00, bus.byte_i}, len: 2'd2,
                           pc: op_pc_q, illegal: 1'b0};
            state_d    = S_OP;
          end else begin
            state_d = S_IMM_HI;
          end
        end
        S_IMM_HI: begin
          push_s     = 1'b1;
          push_pkt_s = '{opcode: op_q, cb: 1'b0, imm: {bus.byte_i, imm_lo_q}, len: 2'd3,
                         pc: op_pc_q, illegal: 1'b0};
          state_d    = S_OP;
        end
        default: begin
          state_d = S_OP;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Packet FIFO: storage, pointers and occupancy; flush wins over push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_s) begin
      count_d  = {CNT_W{1'b0}};
      wr_ptr_d = rd_ptr_q;
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = push_pkt_s;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_OP;
      pc_q     <= RESET_PC;
      op_q     <= 8'h00;
      op_pc_q  <= {PC_W{1'b0}};
      len_q    <= 2'd0;
      imm_lo_q <= 8'h00;
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      op_q     <= op_d;
      op_pc_q  <= op_pc_d;
      len_q    <= len_d;
      imm_lo_q <= imm_lo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end
endmodule
